// File: rtl/delta_dram_arbiter.sv
// Four-requester round-robin arbiter in front of a single-outstanding DRAM port.
// Define DELTA_DRAM_ARB_TIMEOUT_EN to add a response timeout with a sticky timeout_err output.
module delta_dram_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [3:0]             req_write,
  input  logic [3:0][ADDR_W-1:0] req_addr,
  input  logic [3:0][DATA_W-1:0] req_wdata,
  output logic [3:0]             done,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   DRAM_Read,
  output logic                   DRAM_Write,
  output logic [ADDR_W-1:0]      DRAM_Address,
  output logic [DATA_W-1:0]      DRAM_WriteData,
  input  logic [DATA_W-1:0]      DRAM_ReadData,
  input  logic                   DRAM_DataReady,
  input  logic                   DRAM_WriteDone
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [1:0]          last_winner_r, last_winner_s;
  logic                write_r, write_s;
  logic [1:0]          grant_s, pick_s;
  logic [3:0]          done_s;
  logic [DATA_W-1:0]   rdata_s, wdata_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                busy_s, rd_s, wr_s, resp_s, hit_s;

`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                terr_s;
`endif

  // Search starts just after the last winner, so the requester served most recently ranks last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = last + 2'(i + 1);
      if (r[idx] && !found) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s       = state_r;
    last_winner_s = last_winner_r;
    write_s       = write_r;
    grant_s       = grant_id;
    done_s        = 4'b0000;
    rdata_s       = rdata;
    busy_s        = busy;
    rd_s          = DRAM_Read;
    wr_s          = DRAM_Write;
    addr_s        = DRAM_Address;
    wdata_s       = DRAM_WriteData;
    pick_s        = rr_pick(req, last_winner_r);
    resp_s        = write_r ? DRAM_WriteDone : DRAM_DataReady;
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
    cnt_s         = cnt_r;
    terr_s        = timeout_err;
    hit_s         = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    hit_s         = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s = ISSUE;
          grant_s = pick_s;
          write_s = req_write[pick_s];
          rd_s    = ~req_write[pick_s];
          wr_s    = req_write[pick_s];
          addr_s  = req_addr[pick_s];
          wdata_s = req_wdata[pick_s];
          busy_s  = 1'b1;
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
          cnt_s   = {CNT_W{1'b0}};
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // A real response wins over a timeout landing on the same edge.
        if (resp_s || hit_s) begin
          state_s       = DONE;
          rd_s          = 1'b0;
          wr_s          = 1'b0;
          last_winner_s = grant_id;
          done_s        = 4'b0001 << grant_id;
          if (resp_s && !write_r) begin
            rdata_s = DRAM_ReadData;
          end else begin
            rdata_s = rdata;
          end
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
          if (!resp_s) begin
            terr_s = 1'b1;
          end else begin
            terr_s = timeout_err;
          end
`endif
        end else begin
          state_s = ISSUE;
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      last_winner_r  <= 2'd3;
      write_r        <= 1'b0;
      grant_id       <= 2'd0;
      done           <= 4'b0000;
      rdata          <= {DATA_W{1'b0}};
      busy           <= 1'b0;
      DRAM_Read      <= 1'b0;
      DRAM_Write     <= 1'b0;
      DRAM_Address   <= {ADDR_W{1'b0}};
      DRAM_WriteData <= {DATA_W{1'b0}};
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
      cnt_r          <= {CNT_W{1'b0}};
      timeout_err    <= 1'b0;
`endif
    end else begin
      state_r        <= state_s;
      last_winner_r  <= last_winner_s;
      write_r        <= write_s;
      grant_id       <= grant_s;
      done           <= done_s;
      rdata          <= rdata_s;
      busy           <= busy_s;
      DRAM_Read      <= rd_s;
      DRAM_Write     <= wr_s;
      DRAM_Address   <= addr_s;
      DRAM_WriteData <= wdata_s;
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
      cnt_r          <= cnt_s;
      timeout_err    <= terr_s;
`endif
    end
  end

endmodule

// File: tb/tb_delta_dram_arbiter.sv
// Directed self-checking bench for delta_dram_arbiter; cycle n is the period after sampling edge n.
module tb_delta_dram_arbiter;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       req = 4'b0000;
  logic [3:0]       req_write = 4'b0000;
  logic [3:0][31:0] req_addr = '0;
  logic [3:0][31:0] req_wdata = '0;
  logic [3:0]       done;
  logic [31:0]      rdata;
  logic [1:0]       grant_id;
  logic             busy;
  logic             DRAM_Read, DRAM_Write;
  logic [31:0]      DRAM_Address, DRAM_WriteData;
  logic [31:0]      DRAM_ReadData = 32'h0;
  logic             DRAM_DataReady = 1'b0;
  logic             DRAM_WriteDone = 1'b0;
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  delta_dram_arbiter #(
    .ADDR_W(32), .DATA_W(32),
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(8)
`else
    .TIMEOUT_CYCLES(1023)
`endif
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .grant_id(grant_id), .busy(busy), .DRAM_Read(DRAM_Read), .DRAM_Write(DRAM_Write),
    .DRAM_Address(DRAM_Address), .DRAM_WriteData(DRAM_WriteData),
    .DRAM_ReadData(DRAM_ReadData), .DRAM_DataReady(DRAM_DataReady),
    .DRAM_WriteDone(DRAM_WriteDone)
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    req = 4'b0000;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick;
  endtask

  // Waits for a grant, answers it in the first ISSUE cycle, returns what the DUT reported.
  task automatic serve_one(input logic [31:0] data, output logic [1:0] gid,
                           output logic [3:0] dn, output logic [31:0] rd,
                           output int waits, output logic ok);
    waits = 0;
    ok    = 1'b0;
    while (!busy && waits < 20) begin
      tick;
      waits++;
    end
    if (busy) begin
      ok  = 1'b1;
      gid = grant_id;
      if (DRAM_Write) DRAM_WriteDone = 1'b1;
      else begin
        DRAM_DataReady = 1'b1;
        DRAM_ReadData  = data;
      end
      tick;
      DRAM_DataReady = 1'b0;
      DRAM_WriteDone = 1'b0;
      DRAM_ReadData  = 32'h0;
      dn = done;
      rd = rdata;
      req[gid] = 1'b0;
      tick;
    end else begin
      gid = 2'd0;
      dn  = 4'b0000;
      rd  = 32'h0;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({done, busy, DRAM_Read, DRAM_Write, grant_id} !== 10'b0 || rdata !== 32'h0 ||
        DRAM_Address !== 32'h0 || DRAM_WriteData !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: done=%b busy=%b rd=%b wr=%b gid=%0d rdata=%h addr=%h wdata=%h, required all 0",
        done, busy, DRAM_Read, DRAM_Write, grant_id, rdata, DRAM_Address, DRAM_WriteData); end
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000)
      begin errors++; $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done); end
  endtask

  task automatic test_read;
    req_addr[2] = 32'h100;
    req_write   = 4'b0000;
    req         = 4'b0100;
    tick;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (DRAM_Read !== 1'b1 || DRAM_Write !== 1'b0 || DRAM_Address !== 32'h100 ||
          done !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd2)
        begin errors++; $display("FAIL read_issue c%0d: rd=%b wr=%b addr=%h done=%b busy=%b gid=%0d, required 1 0 100 0000 1 2",
          c, DRAM_Read, DRAM_Write, DRAM_Address, done, busy, grant_id); end
      tick;
    end
    DRAM_DataReady = 1'b1;
    DRAM_ReadData  = 32'hCAFE;
    checks++;
    if (DRAM_Read !== 1'b1)
      begin errors++; $display("FAIL read_strobe_c5: rd=%b, required 1", DRAM_Read); end
    tick;
    DRAM_DataReady = 1'b0;
    DRAM_ReadData  = 32'h0;
    checks++;
    if (done !== 4'b0100 || rdata !== 32'hCAFE || DRAM_Read !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL read_done: done=%b rdata=%h rd=%b busy=%b, required 0100 cafe 0 1",
        done, rdata, DRAM_Read, busy); end
    req = 4'b0000;
    tick;
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0)
      begin errors++; $display("FAIL read_after: done=%b busy=%b, required 0000 0", done, busy); end
  endtask

  task automatic test_write;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'hBEEF;
    req_write    = 4'b0010;
    req          = 4'b0010;
    tick;
    req_addr[1]  = 32'hDEAD0000;
    req_wdata[1] = 32'h1234;
    req_write    = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      DRAM_DataReady = (c == 2);
      checks++;
      if (DRAM_Write !== 1'b1 || DRAM_Read !== 1'b0 || DRAM_Address !== 32'h40 ||
          DRAM_WriteData !== 32'hBEEF || done !== 4'b0000 || grant_id !== 2'd1)
        begin errors++; $display("FAIL write_issue c%0d: wr=%b rd=%b addr=%h wdata=%h done=%b gid=%0d, required 1 0 40 beef 0000 1",
          c, DRAM_Write, DRAM_Read, DRAM_Address, DRAM_WriteData, done, grant_id); end
      tick;
    end
    DRAM_DataReady = 1'b0;
    DRAM_WriteDone = 1'b1;
    checks++;
    if (DRAM_Write !== 1'b1 || done !== 4'b0000)
      begin errors++; $display("FAIL write_c4: wr=%b done=%b, required 1 0000", DRAM_Write, done); end
    tick;
    DRAM_WriteDone = 1'b0;
    checks++;
    if (done !== 4'b0010 || DRAM_Write !== 1'b0 || rdata !== 32'hCAFE)
      begin errors++; $display("FAIL write_done: done=%b wr=%b rdata=%h, required 0010 0 cafe", done, DRAM_Write, rdata); end
    req = 4'b0000;
    tick;
  endtask

  task automatic test_round_robin;
    logic [1:0]  gid;
    logic [3:0]  dn;
    logic [31:0] rd;
    int          waits;
    logic        ok;
    apply_reset;
    req_write = 4'b0000;
    req       = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      if (e == 4) req = 4'b1111;
      serve_one(32'hA000 + 32'(e), gid, dn, rd, waits, ok);
      checks++;
      if (!ok || gid !== 2'(e % 4) || dn !== (4'b0001 << (e % 4)) || rd !== 32'hA000 + 32'(e) || waits != 1)
        begin errors++; $display("FAIL rr_grant %0d: ok=%b gid=%0d done=%b rdata=%h waits=%0d, required 1 %0d onehot %h 1",
          e, ok, gid, dn, rd, waits, e % 4, 32'hA000 + 32'(e)); end
      checks++;
      if (busy !== 1'b0 || DRAM_Read !== 1'b0)
        begin errors++; $display("FAIL rr_gap %0d: busy=%b rd=%b, required 0 0", e, busy, DRAM_Read); end
    end
    req = 4'b0000;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [1:0]  gid;
    logic [3:0]  dn;
    logic [31:0] rd;
    int          waits;
    logic        ok;
    req_addr[1] = 32'h80;
    req_write   = 4'b0000;
    req         = 4'b0010;
    tick;
    checks++;
    if (DRAM_Read !== 1'b1)
      begin errors++; $display("FAIL mid_issue: rd=%b, required 1", DRAM_Read); end
    #2 reset = 1'b1;
    req = 4'b0000;
    #1;
    checks++;
    if ({done, busy, DRAM_Read, DRAM_Write, grant_id} !== 10'b0 || rdata !== 32'h0 ||
        DRAM_Address !== 32'h0 || DRAM_WriteData !== 32'h0)
      begin errors++; $display("FAIL mid_async_reset: done=%b busy=%b rd=%b wr=%b gid=%0d rdata=%h addr=%h, required all 0",
        done, busy, DRAM_Read, DRAM_Write, grant_id, rdata, DRAM_Address); end
    #1 reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++;
      if (done !== 4'b0000 || busy !== 1'b0)
        begin errors++; $display("FAIL mid_no_done %0d: done=%b busy=%b, required 0000 0", c, done, busy); end
    end
    req = 4'b0010;
    serve_one(32'h5555, gid, dn, rd, waits, ok);
    checks++;
    if (!ok || gid !== 2'd1 || dn !== 4'b0010 || rd !== 32'h5555)
      begin errors++; $display("FAIL mid_recover: ok=%b gid=%0d done=%b rdata=%h, required 1 1 0010 5555", ok, gid, dn, rd); end
  endtask

  task automatic test_priority;
    logic [1:0]  gid;
    logic [3:0]  dn;
    logic [31:0] rd;
    int          waits;
    logic        ok;
    logic [1:0]  exp_g [6] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0};
    logic [3:0]  new_r [6] = '{4'b1000, 4'b1001, 4'b0000, 4'b0001, 4'b0011, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      req = req | new_r[i];
      serve_one(32'h7000 + 32'(i), gid, dn, rd, waits, ok);
      checks++;
      if (!ok || gid !== exp_g[i] || dn !== (4'b0001 << exp_g[i]))
        begin errors++; $display("FAIL prio %0d: ok=%b gid=%0d done=%b, required 1 %0d", i, ok, gid, dn, exp_g[i]); end
    end
    req = 4'b0000;
    tick;
  endtask

`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    apply_reset;
    req_write = 4'b0000;
    req       = 4'b0001;
    tick;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (DRAM_Read !== 1'b1 || done !== 4'b0000 || timeout_err !== 1'b0)
        begin errors++; $display("FAIL to_wait c%0d: rd=%b done=%b err=%b, required 1 0000 0", c, DRAM_Read, done, timeout_err); end
      tick;
    end
    checks++;
    if (DRAM_Read !== 1'b0 || done !== 4'b0001 || timeout_err !== 1'b1 || rdata !== 32'h0)
      begin errors++; $display("FAIL to_fire: rd=%b done=%b err=%b rdata=%h, required 0 0001 1 0", DRAM_Read, done, timeout_err, rdata); end
    req = 4'b0000;
    tick;
    tick;
    checks++;
    if (timeout_err !== 1'b1)
      begin errors++; $display("FAIL to_sticky: err=%b, required 1", timeout_err); end
    apply_reset;
    checks++;
    if (timeout_err !== 1'b0)
      begin errors++; $display("FAIL to_clear: err=%b, required 0", timeout_err); end
  endtask
`endif

  initial begin
    test_reset;
    test_read;
    test_write;
    test_round_robin;
    test_reset_mid;
    test_priority;
`ifdef DELTA_DRAM_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
